wb_arbiter_2m: RTL and testbench

- Two-master, one-slave Wishbone arbiter.
- Lets two `core` instances share one `memory_wb`; this is the first step toward the multi-core simulation.
- Round-robin grant, held for the whole bus cycle (`cyc` high).
- A watchdog releases the bus if the slave never acks.

---
 rtl/wb_arbiter_2m.sv | 148 ++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_2m.sv
// Two-master, one-slave Wishbone arbiter with round-robin
// grant held per bus cycle and an un-acked access watchdog.
module wb_arbiter_2m #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int TIMEOUT_CLKS = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_m0_wb_cyc,
    input  logic            i_m0_wb_stb,
    input  logic            i_m0_wb_we,
    input  logic [DW/8-1:0] i_m0_wb_sel,
    input  logic [AW-1:0]   i_m0_wb_adr,
    input  logic [DW-1:0]   i_m0_wb_dat,
    output logic [DW-1:0]   o_m0_wb_dat,
    output logic            o_m0_wb_ack,
    input  logic            i_m1_wb_cyc,
    input  logic            i_m1_wb_stb,
    input  logic            i_m1_wb_we,
    input  logic [DW/8-1:0] i_m1_wb_sel,
    input  logic [AW-1:0]   i_m1_wb_adr,
    input  logic [DW-1:0]   i_m1_wb_dat,
    output logic [DW-1:0]   o_m1_wb_dat,
    output logic            o_m1_wb_ack,
    output logic            o_s_wb_cyc,
    output logic            o_s_wb_stb,
    output logic            o_s_wb_we,
    output logic [DW/8-1:0] o_s_wb_sel,
    output logic [AW-1:0]   o_s_wb_adr,
    output logic [DW-1:0]   o_s_wb_dat,
    input  logic [DW-1:0]   i_s_wb_dat,
    input  logic            i_s_wb_ack,
    output logic [1:0]      o_grant,
    output logic            o_timeout
);

    localparam int CW = (TIMEOUT_CLKS > 0) ?
                        $clog2(TIMEOUT_CLKS + 1) : 1;
    localparam int LIM_I = (TIMEOUT_CLKS > 0) ?
                           TIMEOUT_CLKS - 1 : 0;
    localparam logic [CW-1:0] LIMIT = CW'(LIM_I);

    // One-hot encoding so the grant output is the state itself.
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] GNT0 = 2'b01;
    localparam logic [1:0] GNT1 = 2'b10;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          last_grant;
    logic          abort;
    logic [CW-1:0] wd_cnt;
    logic          wd_hit;

    assign o_grant   = state;
    assign o_timeout = abort;

    assign wd_hit = (TIMEOUT_CLKS > 0) && (state != IDLE) &&
                    !abort && o_s_wb_cyc && o_s_wb_stb &&
                    !i_s_wb_ack && (wd_cnt == LIMIT);

    // Route the owner onto the slave; abort overrides with a fake ack.
    always_comb begin
        o_s_wb_cyc  = 1'b0;
        o_s_wb_stb  = 1'b0;
        o_s_wb_we   = 1'b0;
        o_s_wb_sel  = '0;
        o_s_wb_adr  = '0;
        o_s_wb_dat  = '0;
        o_m0_wb_dat = '0;
        o_m0_wb_ack = 1'b0;
        o_m1_wb_dat = '0;
        o_m1_wb_ack = 1'b0;
        unique case (state)
            GNT0: begin
                o_s_wb_cyc  = i_m0_wb_cyc;
                o_s_wb_stb  = i_m0_wb_stb;
                o_s_wb_we   = i_m0_wb_we;
                o_s_wb_sel  = i_m0_wb_sel;
                o_s_wb_adr  = i_m0_wb_adr;
                o_s_wb_dat  = i_m0_wb_dat;
                o_m0_wb_dat = i_s_wb_dat;
                o_m0_wb_ack = i_s_wb_ack;
            end
            GNT1: begin
                o_s_wb_cyc  = i_m1_wb_cyc;
                o_s_wb_stb  = i_m1_wb_stb;
                o_s_wb_we   = i_m1_wb_we;
                o_s_wb_sel  = i_m1_wb_sel;
                o_s_wb_adr  = i_m1_wb_adr;
                o_s_wb_dat  = i_m1_wb_dat;
                o_m1_wb_dat = i_s_wb_dat;
                o_m1_wb_ack = i_s_wb_ack;
            end
            default: ;
        endcase
        if (abort) begin
            o_s_wb_cyc  = 1'b0;
            o_s_wb_stb  = 1'b0;
            o_m0_wb_dat = '0;
            o_m1_wb_dat = '0;
            o_m0_wb_ack = (state == GNT0);
            o_m1_wb_ack = (state == GNT1);
        end
    end

    // Round-robin pick in IDLE; owner keeps the bus until cyc drops.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (i_m0_wb_cyc && i_m1_wb_cyc)
                    state_nxt = last_grant ? GNT0 : GNT1;
                else if (i_m0_wb_cyc)
                    state_nxt = GNT0;
                else if (i_m1_wb_cyc)
                    state_nxt = GNT1;
            end
            GNT0: if (abort || !i_m0_wb_cyc) state_nxt = IDLE;
            GNT1: if (abort || !i_m1_wb_cyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant state, fairness memory and the one-cycle abort flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            abort      <= 1'b0;
        end else begin
            state <= state_nxt;
            abort <= wd_hit;
            if (state != IDLE && state_nxt == IDLE)
                last_grant <= (state == GNT1);
        end
    end

    // Count strobed cycles without ack; saturates rather than wraps.
    always_ff @(posedge i_clk) begin
        if (i_rst || abort || i_s_wb_ack || state_nxt != state)
            wd_cnt <= '0;
        else if (o_s_wb_cyc && o_s_wb_stb && wd_cnt != '1)
            wd_cnt <= wd_cnt + CW'(1);
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: directed master cycles push
// expected responses, a negedge monitor pops and compares them.
module tb_wb_arbiter_2m;

    typedef struct packed {
        logic [1:0]  ack;
        logic        to;
        logic        scyc;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic [31:0] rdat0;
        logic [31:0] rdat1;
        logic [1:0]  grant;
        logic [7:0]  wait_cyc;
    } rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_wdat[2];
    logic [31:0] m0_rdat, m1_rdat;
    logic        m0_ack, m1_ack;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_adr, s_wdat;
    logic [31:0] s_rdat = 32'h0;
    logic        s_ack = 1'b0;
    logic [1:0]  grant;
    logic        tout;

    wb_arbiter_2m #(.AW(32), .DW(32), .TIMEOUT_CLKS(8)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_m0_wb_cyc(m_cyc[0]), .i_m0_wb_stb(m_stb[0]),
        .i_m0_wb_we(m_we[0]), .i_m0_wb_sel(m_sel[0]),
        .i_m0_wb_adr(m_adr[0]), .i_m0_wb_dat(m_wdat[0]),
        .o_m0_wb_dat(m0_rdat), .o_m0_wb_ack(m0_ack),
        .i_m1_wb_cyc(m_cyc[1]), .i_m1_wb_stb(m_stb[1]),
        .i_m1_wb_we(m_we[1]), .i_m1_wb_sel(m_sel[1]),
        .i_m1_wb_adr(m_adr[1]), .i_m1_wb_dat(m_wdat[1]),
        .o_m1_wb_dat(m1_rdat), .o_m1_wb_ack(m1_ack),
        .o_s_wb_cyc(s_cyc), .o_s_wb_stb(s_stb),
        .o_s_wb_we(s_we), .o_s_wb_sel(s_sel),
        .o_s_wb_adr(s_adr), .o_s_wb_dat(s_wdat),
        .i_s_wb_dat(s_rdat), .i_s_wb_ack(s_ack),
        .o_grant(grant), .o_timeout(tout)
    );

    // Slave: data = adr[15:0] ^ 0x155, ack after ack_delay waits.
    logic ack_en = 1'b1;
    int   ack_delay = 0;
    int   wcnt = 0;
    always @(posedge clk) begin
        s_rdat <= {16'h0, s_adr[15:0]} ^ 32'h155;
        if (s_cyc && s_stb && !s_ack) begin
            if (ack_en && wcnt >= ack_delay) begin
                s_ack <= 1'b1;
                wcnt  <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            s_ack <= 1'b0;
            wcnt  <= 0;
        end
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    rec_t q[$];

    task automatic chk(input string name,
                       input logic [159:0] act,
                       input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h",
                     name, act, exp);
        end
    endtask

    function automatic rec_t mk(
        input logic [1:0] ack, input logic to,
        input logic scyc, input logic we,
        input logic [31:0] adr, input logic [31:0] wd,
        input logic [31:0] rd0, input logic [31:0] rd1,
        input logic [1:0] g, input int w);
        rec_t r;
        r.ack = ack;   r.to = to;     r.scyc = scyc;
        r.we = we;     r.adr = adr;   r.wdat = wd;
        r.rdat0 = rd0; r.rdat1 = rd1; r.grant = g;
        r.wait_cyc = 8'(w);
        return r;
    endfunction

    // Monitor: compare every ack/timeout; grants start only from idle.
    initial begin
        int         run;
        logic [1:0] prev_g;
        rec_t       got;
        rec_t       exp;
        run = 0;
        prev_g = 2'b00;
        forever begin
            @(negedge clk);
            if (grant != 2'b00 && grant != prev_g)
                chk("idle_gap", 160'(prev_g), 160'(2'b00));
            prev_g = grant;
            if (m0_ack || m1_ack || tout) begin
                got = mk({m1_ack, m0_ack}, tout, s_cyc, s_we,
                         s_adr, s_wdat, m0_rdat, m1_rdat,
                         grant, run);
                if (q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_resp: got %h, expected none",
                             got);
                end else begin
                    exp = q.pop_front();
                    chk("resp", 160'(got), 160'(exp));
                end
            end
            run = (s_cyc && s_stb && !s_ack) ? run + 1 : 0;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
    endtask

    // One bus cycle of nb beats; stb drops for a cycle between beats.
    task automatic mcycle(input int m, input int nb, input logic we,
                          input logic [31:0] adr0,
                          input logic [31:0] wd0);
        for (int b = 0; b < nb; b++) begin
            int   n;
            logic got;
            m_cyc[m]  = 1'b1;
            m_stb[m]  = 1'b1;
            m_we[m]   = we;
            m_sel[m]  = 4'hF;
            m_adr[m]  = adr0 + 32'(4 * b);
            m_wdat[m] = we ? wd0 + 32'(b) : 32'h0;
            n = 0;
            got = 1'b0;
            while (!got && n < 60) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack : m1_ack;
                n++;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_wait m%0d: got no ack, expected ack", m);
            end
            idle(1);
            if (b < nb - 1) begin
                m_stb[m] = 1'b0;
                idle(1);
            end
        end
        m_cyc[m]  = 1'b0;
        m_stb[m]  = 1'b0;
        m_we[m]   = 1'b0;
        m_sel[m]  = 4'h0;
        m_adr[m]  = 32'h0;
        m_wdat[m] = 32'h0;
    endtask

    rec_t r0_rd, r1_rd;

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_stb[i] = 0; m_we[i] = 0;
            m_sel[i] = 0; m_adr[i] = 0; m_wdat[i] = 0;
        end
        r0_rd = mk(2'b01, 0, 1, 0, 32'h140, 0, 32'h15, 0, 2'b01, 1);
        r1_rd = mk(2'b10, 0, 1, 0, 32'h180, 0, 0, 32'hD5, 2'b10, 1);

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_grant", 160'(grant), 160'(2'b00));
        chk("rst_timeout", 160'(tout), 160'(1'b0));
        chk("rst_s_ctl", 160'({s_cyc, s_stb, s_we, s_sel}), 160'(0));
        chk("rst_s_adr_dat", 160'({s_adr, s_wdat}), 160'(0));
        chk("rst_m_ack", 160'({m0_ack, m1_ack}), 160'(0));
        chk("rst_m_dat", 160'({m0_rdat, m1_rdat}), 160'(0));
        idle(1);

        // Single m0 read.
        q.push_back(r0_rd);
        mcycle(0, 1, 1'b0, 32'h140, 32'h0);
        @(negedge clk);
        chk("drop_grant_held", 160'(grant), 160'(2'b01));
        chk("drop_s_cyc", 160'(s_cyc), 160'(1'b0));
        @(negedge clk);
        chk("drop_grant_idle", 160'(grant), 160'(2'b00));
        idle(1);

        // Four rounds of simultaneous requests: 0,1,0,1,...
        do_reset();
        idle(1);
        for (int r = 0; r < 4; r++) begin
            q.push_back(r0_rd);
            q.push_back(r1_rd);
            fork
                mcycle(0, 1, 1'b0, 32'h140, 32'h0);
                mcycle(1, 1, 1'b0, 32'h180, 32'h0);
            join
            idle(1);
        end

        // m0 3-beat write burst while m1 waits.
        q.push_back(mk(2'b01, 0, 1, 1, 32'h100, 32'hA0, 32'h055, 0, 2'b01, 1));
        q.push_back(mk(2'b01, 0, 1, 1, 32'h104, 32'hA1, 32'h051, 0, 2'b01, 1));
        q.push_back(mk(2'b01, 0, 1, 1, 32'h108, 32'hA2, 32'h05D, 0, 2'b01, 1));
        q.push_back(r1_rd);
        fork
            mcycle(0, 3, 1'b1, 32'h100, 32'hA0);
            begin
                idle(1);
                mcycle(1, 1, 1'b0, 32'h180, 32'h0);
            end
        join
        idle(1);

        // Watchdog: slave never acks; m1 then pending m0 both abort.
        ack_en = 1'b0;
        q.push_back(mk(2'b10, 1, 0, 0, 32'h180, 0, 0, 0, 2'b10, 8));
        q.push_back(mk(2'b01, 1, 0, 0, 32'h140, 0, 0, 0, 2'b01, 8));
        fork
            mcycle(1, 1, 1'b0, 32'h180, 32'h0);
            begin
                idle(2);
                mcycle(0, 1, 1'b0, 32'h140, 32'h0);
            end
        join
        ack_en = 1'b1;
        idle(1);

        // Ack lands exactly when the count is at its limit.
        ack_delay = 6;
        q.push_back(mk(2'b01, 0, 1, 0, 32'h200, 0, 32'h355, 0, 2'b01, 7));
        mcycle(0, 1, 1'b0, 32'h200, 32'h0);
        ack_delay = 0;
        idle(1);

        // Reset during a GNT1 transfer.
        ack_en = 1'b0;
        m_cyc[1] = 1'b1; m_stb[1] = 1'b1; m_sel[1] = 4'hF;
        m_adr[1] = 32'h180;
        idle(3);
        @(negedge clk);
        chk("pre_rst_grant", 160'(grant), 160'(2'b10));
        idle(0);
        do_reset();
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; m_sel[1] = 4'h0;
        m_adr[1] = 32'h0;
        @(negedge clk);
        chk("mid_rst_grant", 160'(grant), 160'(2'b00));
        chk("mid_rst_s_ctl", 160'({s_cyc, s_stb, s_we, s_sel}), 160'(0));
        chk("mid_rst_s_adr", 160'(s_adr), 160'(0));
        chk("mid_rst_timeout", 160'(tout), 160'(1'b0));
        ack_en = 1'b1;
        idle(1);
        q.push_back(r0_rd);
        q.push_back(r1_rd);
        fork
            mcycle(0, 1, 1'b0, 32'h140, 32'h0);
            mcycle(1, 1, 1'b0, 32'h180, 32'h0);
        join
        idle(1);

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 160'(q.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
